// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer : hardwired Mini-SRC fetch/decode/execute control unit.
// Optional mul/div support via CONTROL_MUL_DIV_EN.            Revision 1.0
// ============================================================================
module control_sequencer #(
  parameter int OPC_W = 5,
  parameter int ALU_W = 4
) (
  input  logic             clk,
  input  logic             in_reset_n,
  input  logic [31:0]      in_ir,
  input  logic             in_branch,
  input  logic             in_run,
  output logic [ALU_W-1:0] out_alu_opcode,
  output logic             out_reg_clear,
  output logic             out_mdr_select,
  output logic             out_inc_pc,
  output logic             out_gra,
  output logic             out_grb,
  output logic             out_grc,
  output logic             out_ba_read,
  output logic             out_con_in,
  output logic             out_regfile_read,
  output logic             out_hi_read,
  output logic             out_lo_read,
  output logic             out_z_hi_read,
  output logic             out_z_lo_read,
  output logic             out_pc_read,
  output logic             out_mdr_read,
  output logic             out_inport_read,
  output logic             out_c_read,
  output logic             out_mem_read,
  output logic             out_regfile_write,
  output logic             out_hi_write,
  output logic             out_lo_write,
  output logic             out_z_write,
  output logic             out_pc_write,
  output logic             out_mdr_write,
  output logic             out_ir_write,
  output logic             out_y_write,
  output logic             out_mar_write,
  output logic             out_mem_write,
  output logic             out_outport_write,
  output logic [3:0]       out_step,
  output logic             out_halted,
  output logic             out_illegal
);

  // T0..T7 occupy 0..7 so the step number doubles as a sequence counter.
  localparam logic [3:0] S_T0   = 4'd0;
  localparam logic [3:0] S_T1   = 4'd1;
  localparam logic [3:0] S_T2   = 4'd2;
  localparam logic [3:0] S_T3   = 4'd3;
  localparam logic [3:0] S_T4   = 4'd4;
  localparam logic [3:0] S_T5   = 4'd5;
  localparam logic [3:0] S_T6   = 4'd6;
  localparam logic [3:0] S_T7   = 4'd7;
  localparam logic [3:0] S_RST  = 4'd8;
  localparam logic [3:0] S_STOP = 4'd9;
  localparam logic [3:0] S_HALT = 4'd10;

  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b01001);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(5'b10010);
  localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(5'b10101);
  localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(5'b10110);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11001);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11010);

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(4'b0000);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(4'b0001);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(4'b0010);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4'b0011);

`ifdef CONTROL_MUL_DIV_EN
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(5'b01110);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(5'b01111);
  localparam logic [ALU_W-1:0] ALU_MUL = ALU_W'(4'b1000);
  localparam logic [ALU_W-1:0] ALU_DIV = ALU_W'(4'b1001);
`endif

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic             illegal_q;
  logic             illegal_d;
  logic [OPC_W-1:0] opcode;
  logic [3:0]       last_step;
  logic             op_legal;
  logic [ALU_W-1:0] alu_sel;
  logic             unused_ir;

  assign opcode    = in_ir[31 -: OPC_W];
  assign unused_ir = ^in_ir[31-OPC_W:0];

  // Instruction length and ALU function, both pure functions of the opcode.
  always_comb begin
    last_step = S_T2;
    op_legal  = 1'b1;
    alu_sel   = ALU_ADD;
    case (opcode)
      OP_ADD, OP_ADDI:         last_step = S_T5;
      OP_SUB: begin
        last_step = S_T5;
        alu_sel   = ALU_SUB;
      end
      OP_AND: begin
        last_step = S_T5;
        alu_sel   = ALU_AND;
      end
      OP_OR: begin
        last_step = S_T5;
        alu_sel   = ALU_OR;
      end
      OP_LD, OP_ST:            last_step = S_T7;
      OP_BR:                   last_step = S_T6;
      OP_IN, OP_OUT:           last_step = S_T3;
`ifdef CONTROL_MUL_DIV_EN
      OP_MUL: begin
        last_step = S_T6;
        alu_sel   = ALU_MUL;
      end
      OP_DIV: begin
        last_step = S_T6;
        alu_sel   = ALU_DIV;
      end
`endif
      OP_NOP, OP_HALT:         last_step = S_T2;
      default:                 op_legal  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RST, S_STOP: state_d = in_run ? S_T0 : S_STOP;
      S_HALT:        state_d = S_HALT;
      default: begin
        // Any step at or past the opcode's final step ends the instruction,
        // which also recovers the unused encodings.
        if ((state_q == S_T2) && (opcode == OP_HALT)) begin
          state_d = S_HALT;
        end else if (state_q >= last_step) begin
          state_d = in_run ? S_T0 : S_STOP;
        end else begin
          state_d = state_q + 4'd1;
        end
        if ((state_q == S_T2) && !op_legal) begin
          illegal_d = 1'b1;
        end
      end
    endcase
  end

  assign out_step    = state_q;
  assign out_illegal = illegal_q;

  always_comb begin
    out_alu_opcode    = ALU_ADD;
    out_reg_clear     = 1'b0;
    out_mdr_select    = 1'b0;
    out_inc_pc        = 1'b0;
    out_gra           = 1'b0;
    out_grb           = 1'b0;
    out_grc           = 1'b0;
    out_ba_read       = 1'b0;
    out_con_in        = 1'b0;
    out_regfile_read  = 1'b0;
    out_hi_read       = 1'b0;
    out_lo_read       = 1'b0;
    out_z_hi_read     = 1'b0;
    out_z_lo_read     = 1'b0;
    out_pc_read       = 1'b0;
    out_mdr_read      = 1'b0;
    out_inport_read   = 1'b0;
    out_c_read        = 1'b0;
    out_mem_read      = 1'b0;
    out_regfile_write = 1'b0;
    out_hi_write      = 1'b0;
    out_lo_write      = 1'b0;
    out_z_write       = 1'b0;
    out_pc_write      = 1'b0;
    out_mdr_write     = 1'b0;
    out_ir_write      = 1'b0;
    out_y_write       = 1'b0;
    out_mar_write     = 1'b0;
    out_mem_write     = 1'b0;
    out_outport_write = 1'b0;
    out_halted        = 1'b0;
    case (state_q)
      S_RST:  out_reg_clear = 1'b1;
      S_HALT: out_halted    = 1'b1;
      S_T0: begin
        out_pc_read   = 1'b1;
        out_mar_write = 1'b1;
        out_inc_pc    = 1'b1;
        out_pc_write  = 1'b1;
        out_mem_read  = 1'b1;
      end
      S_T1: begin
        out_mdr_write  = 1'b1;
        out_mdr_select = 1'b1;
      end
      S_T2: begin
        out_mdr_read = 1'b1;
        out_ir_write = 1'b1;
      end
      S_T3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            out_grb          = 1'b1;
            out_regfile_read = 1'b1;
            out_y_write      = 1'b1;
          end
          OP_LD, OP_ST: begin
            out_grb     = 1'b1;
            out_ba_read = 1'b1;
            out_y_write = 1'b1;
          end
          OP_BR: begin
            out_gra          = 1'b1;
            out_regfile_read = 1'b1;
            out_con_in       = 1'b1;
          end
          OP_IN: begin
            out_inport_read   = 1'b1;
            out_gra           = 1'b1;
            out_regfile_write = 1'b1;
          end
          OP_OUT: begin
            out_gra           = 1'b1;
            out_regfile_read  = 1'b1;
            out_outport_write = 1'b1;
          end
`ifdef CONTROL_MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            out_gra          = 1'b1;
            out_regfile_read = 1'b1;
            out_y_write      = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T4: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            out_grc          = 1'b1;
            out_regfile_read = 1'b1;
            out_alu_opcode   = alu_sel;
            out_z_write      = 1'b1;
          end
          OP_ADDI, OP_LD, OP_ST: begin
            out_c_read     = 1'b1;
            out_alu_opcode = ALU_ADD;
            out_z_write    = 1'b1;
          end
          OP_BR: begin
            out_pc_read = 1'b1;
            out_y_write = 1'b1;
          end
`ifdef CONTROL_MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            out_grb          = 1'b1;
            out_regfile_read = 1'b1;
            out_alu_opcode   = alu_sel;
            out_z_write      = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            out_gra           = 1'b1;
            out_z_lo_read     = 1'b1;
            out_regfile_write = 1'b1;
          end
          OP_LD, OP_ST: begin
            out_z_lo_read = 1'b1;
            out_mar_write = 1'b1;
          end
          OP_BR: begin
            out_c_read     = 1'b1;
            out_alu_opcode = ALU_ADD;
            out_z_write    = 1'b1;
          end
`ifdef CONTROL_MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            out_z_lo_read = 1'b1;
            out_lo_write  = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_LD: begin
            out_mdr_write  = 1'b1;
            out_mdr_select = 1'b1;
            out_mem_read   = 1'b1;
          end
          OP_ST: begin
            out_gra          = 1'b1;
            out_regfile_read = 1'b1;
            out_mdr_write    = 1'b1;
          end
          OP_BR: begin
            // PC load is conditional on the live CON FF result.
            out_z_lo_read = 1'b1;
            out_pc_write  = in_branch;
          end
`ifdef CONTROL_MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            out_z_hi_read = 1'b1;
            out_hi_write  = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD: begin
            out_mdr_read      = 1'b1;
            out_gra           = 1'b1;
            out_regfile_write = 1'b1;
          end
          OP_ST:   out_mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// tb_control_sequencer : randomized instruction stream checked against a
// per-instruction strobe-sequence model of the Mini-SRC control unit.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        in_reset_n;
  logic [31:0] in_ir;
  logic        in_branch;
  logic        in_run;
  logic [3:0]  alu;
  logic reg_clear, mdr_select, inc_pc, gra, grb, grc, ba_read, con_in;
  logic regfile_read, hi_read, lo_read, z_hi_read, z_lo_read, pc_read;
  logic mdr_read, inport_read, c_read, mem_read;
  logic regfile_write, hi_write, lo_write, z_write, pc_write, mdr_write;
  logic ir_write, y_write, mar_write, mem_write, outport_write;
  logic [3:0] step;
  logic halted, illegal;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .in_reset_n(in_reset_n), .in_ir(in_ir), .in_branch(in_branch),
    .in_run(in_run), .out_alu_opcode(alu), .out_reg_clear(reg_clear),
    .out_mdr_select(mdr_select), .out_inc_pc(inc_pc), .out_gra(gra),
    .out_grb(grb), .out_grc(grc), .out_ba_read(ba_read), .out_con_in(con_in),
    .out_regfile_read(regfile_read), .out_hi_read(hi_read),
    .out_lo_read(lo_read), .out_z_hi_read(z_hi_read),
    .out_z_lo_read(z_lo_read), .out_pc_read(pc_read),
    .out_mdr_read(mdr_read), .out_inport_read(inport_read),
    .out_c_read(c_read), .out_mem_read(mem_read),
    .out_regfile_write(regfile_write), .out_hi_write(hi_write),
    .out_lo_write(lo_write), .out_z_write(z_write),
    .out_pc_write(pc_write), .out_mdr_write(mdr_write),
    .out_ir_write(ir_write), .out_y_write(y_write),
    .out_mar_write(mar_write), .out_mem_write(mem_write),
    .out_outport_write(outport_write), .out_step(step),
    .out_halted(halted), .out_illegal(illegal)
  );

  // Every observable strobe packed into one word, one named bit each.
  logic [33:0] obs;
  assign obs = {alu, con_in, ba_read, grc, grb, gra, inc_pc, mdr_select,
                reg_clear, mem_read, c_read, inport_read, mdr_read, pc_read,
                z_lo_read, z_hi_read, lo_read, hi_read, regfile_read,
                outport_write, mem_write, mar_write, y_write, ir_write,
                mdr_write, pc_write, z_write, lo_write, hi_write,
                regfile_write, halted};

  localparam logic [33:0] HALTED = 34'd1 << 0;
  localparam logic [33:0] RFW    = 34'd1 << 1;
  localparam logic [33:0] HIW    = 34'd1 << 2;
  localparam logic [33:0] LOW    = 34'd1 << 3;
  localparam logic [33:0] ZW     = 34'd1 << 4;
  localparam logic [33:0] PCW    = 34'd1 << 5;
  localparam logic [33:0] MDRW   = 34'd1 << 6;
  localparam logic [33:0] IRW    = 34'd1 << 7;
  localparam logic [33:0] YW     = 34'd1 << 8;
  localparam logic [33:0] MARW   = 34'd1 << 9;
  localparam logic [33:0] MEMW   = 34'd1 << 10;
  localparam logic [33:0] OUTW   = 34'd1 << 11;
  localparam logic [33:0] RFR    = 34'd1 << 12;
  localparam logic [33:0] ZHR    = 34'd1 << 15;
  localparam logic [33:0] ZLR    = 34'd1 << 16;
  localparam logic [33:0] PCR    = 34'd1 << 17;
  localparam logic [33:0] MDRR   = 34'd1 << 18;
  localparam logic [33:0] INR    = 34'd1 << 19;
  localparam logic [33:0] CR     = 34'd1 << 20;
  localparam logic [33:0] MEMR   = 34'd1 << 21;
  localparam logic [33:0] REGCLR = 34'd1 << 22;
  localparam logic [33:0] MDRSEL = 34'd1 << 23;
  localparam logic [33:0] INCPC  = 34'd1 << 24;
  localparam logic [33:0] GRA    = 34'd1 << 25;
  localparam logic [33:0] GRB    = 34'd1 << 26;
  localparam logic [33:0] GRC    = 34'd1 << 27;
  localparam logic [33:0] BAR    = 34'd1 << 28;
  localparam logic [33:0] CONIN  = 34'd1 << 29;

  int total = 0;
  int passed = 0;
  int failed = 0;
  logic ill_model;
  logic [34:0] exp_q[$];   // {set-illegal-after-this-cycle, strobe word}

  function automatic logic [33:0] aluf(input logic [3:0] c);
    return {c, 30'd0};
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    logic [4:0] ops[$];
    ops = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b01001, 5'b01010,
            5'b01011, 5'b10010, 5'b10101, 5'b10110, 5'b11001, 5'b11010};
`ifdef CONTROL_MUL_DIV_EN
    ops.push_back(5'b01110);
    ops.push_back(5'b01111);
`endif
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [33:0] v);
    exp_q.push_back({1'b0, v});
  endtask

  // Expected strobe word for each cycle of one instruction, fetch included.
  task automatic plan(input logic [4:0] op, input logic b);
    logic [3:0] code;
    push(PCR | MARW | INCPC | PCW | MEMR);
    push(MDRW | MDRSEL);
    exp_q.push_back({!is_legal(op), MDRR | IRW});
    case (op)
      5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
        code = (op == 5'b00011) ? 4'd0 : (op == 5'b00100) ? 4'd1 :
               (op == 5'b01001) ? 4'd2 : 4'd3;
        push(GRB | RFR | YW);
        push(GRC | RFR | ZW | aluf(code));
        push(GRA | ZLR | RFW);
      end
      5'b01011: begin
        push(GRB | RFR | YW);
        push(CR | ZW);
        push(GRA | ZLR | RFW);
      end
      5'b00000, 5'b00010: begin
        push(GRB | BAR | YW);
        push(CR | ZW);
        push(ZLR | MARW);
        if (op == 5'b00000) begin
          push(MDRW | MDRSEL | MEMR);
          push(MDRR | GRA | RFW);
        end else begin
          push(GRA | RFR | MDRW);
          push(MEMW);
        end
      end
      5'b10010: begin
        push(GRA | RFR | CONIN);
        push(PCR | YW);
        push(CR | ZW);
        push(ZLR | (b ? PCW : 34'd0));
      end
      5'b10101: push(INR | GRA | RFW);
      5'b10110: push(GRA | RFR | OUTW);
`ifdef CONTROL_MUL_DIV_EN
      5'b01110, 5'b01111: begin
        push(GRA | RFR | YW);
        push(GRB | RFR | ZW | aluf(op == 5'b01110 ? 4'd8 : 4'd9));
        push(ZLR | LOW);
        push(ZHR | HIW);
      end
`endif
      default: ;
    endcase
  endtask

  // Called with the DUT showing T0; leaves it in T0, STOP or HALT.
  task automatic run_instr(input logic [31:0] ir, input logic b,
                           input logic next_run, input int drop_at);
    logic [34:0] e;
    in_ir     = ir;
    in_branch = b;
    plan(ir[31:27], b);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("ir=%08h step%0d", ir, i), 64'(obs), 64'(e[33:0]));
      chk($sformatf("ir=%08h illegal%0d", ir, i), 64'(illegal), 64'(ill_model));
      if (e[34]) ill_model = 1'b1;
      if (i == drop_at || exp_q.size() == 0) in_run = next_run;
      tick;
    end
  endtask

  task automatic idle_stop(input int k);
    for (int i = 0; i < k; i++) begin
      chk("stop idle", 64'(obs), 64'd0);
      tick;
    end
    in_run = 1'b1;
    chk("stop release", 64'(obs), 64'd0);
    tick;
  endtask

  initial begin
    logic [4:0]  op;
    logic        b;
    logic        nr;
    in_reset_n = 1'b0;
    in_run     = 1'b1;
    in_ir      = 32'd0;
    in_branch  = 1'b0;
    ill_model  = 1'b0;
    tick;
    tick;
    chk("reset strobes", 64'(obs), 64'(REGCLR));
    chk("reset illegal", 64'(illegal), 64'd0);
    in_reset_n = 1'b1;
    chk("rst after release", 64'(obs), 64'(REGCLR));
    tick;

    run_instr(32'h18918000, 1'b0, 1'b1, 99);   // add
    run_instr(32'h00800055, 1'b0, 1'b1, 99);   // ld
    run_instr(32'h10800055, 1'b0, 1'b1, 99);   // st
    run_instr(32'h91000004, 1'b1, 1'b1, 99);   // br taken
    run_instr(32'h91000004, 1'b0, 1'b1, 99);   // br not taken
    run_instr(32'hF8000000, 1'b0, 1'b1, 99);   // illegal
    run_instr(32'h18918000, 1'b0, 1'b0, 4);    // run dropped in T4
    idle_stop(3);
    run_instr(32'h71000000, 1'b0, 1'b1, 99);   // mul opcode
    run_instr(32'h79000000, 1'b0, 1'b1, 99);   // div opcode

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom);
      else begin
        case ($urandom_range(0, 10))
          0: op = 5'b00000;  1: op = 5'b00010;  2: op = 5'b00011;
          3: op = 5'b00100;  4: op = 5'b01001;  5: op = 5'b01010;
          6: op = 5'b01011;  7: op = 5'b10010;  8: op = 5'b10101;
          9: op = 5'b10110;  default: op = 5'b11001;
        endcase
      end
      if (op == 5'b11010) op = 5'b11001;
      b  = 1'($urandom);
      nr = ($urandom_range(0, 3) != 0);
      run_instr({op, 27'($urandom)}, b, nr, $urandom_range(0, 7));
      if (!nr) idle_stop($urandom_range(1, 3));
    end

    // Reset in the middle of a load: strobes drop at once, flag clears.
    in_ir = 32'h00800055;
    for (int i = 0; i < 4; i++) tick;
    in_reset_n = 1'b0;
    #1;
    chk("mid reset strobes", 64'(obs), 64'(REGCLR));
    chk("mid reset illegal", 64'(illegal), 64'd0);
    ill_model = 1'b0;
    tick;
    in_reset_n = 1'b1;
    tick;
    run_instr(32'h18918000, 1'b0, 1'b1, 99);

    run_instr(32'hD0000000, 1'b0, 1'b1, 99);   // halt
    for (int i = 0; i < 20; i++) begin
      in_run = 1'($urandom);
      chk($sformatf("halt hold %0d", i), 64'(obs), 64'(HALTED));
      tick;
    end
    in_run     = 1'b1;
    in_reset_n = 1'b0;
    #1;
    chk("halt reset", 64'(obs), 64'(REGCLR));
    tick;
    in_reset_n = 1'b1;
    tick;
    chk("t0 after halt reset", 64'(obs), 64'(PCR | MARW | INCPC | PCW | MEMR));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
